// File: rtl/control_sequencer_if.sv
// Control bus between the Mini SRC sequencer (master) and the datapath (slave):
// the instruction and memory handshake come in, and the step strobes go out.
interface control_sequencer_if;
   logic [31:0] IR;
   logic        mem_ready;
   logic        PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Cout;
   logic        Gra, Grb, Grc, Rin, Rout, BAout;
   logic [4:0]  alu_op;
   logic        run;
   logic [3:0]  step;

   modport master (
      input  IR, mem_ready,
      output PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
      output Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
      output alu_op, run, step
   );

   modport slave (
      output IR, mem_ready,
      input  PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin,
      input  Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
      input  alu_op, run, step
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: Moore fetch/decode/execute step machine whose
// strobes decode from the current step and the IR opcode.
module control_sequencer (
   input  logic                       clock,
   input  logic                       clear,
   control_sequencer_if.master        bus
);
   typedef enum logic [3:0] {
      S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4  = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
   } state_t;

   state_t     r_state;
   logic [4:0] w_opcode;
   logic [4:0] w_imm_alu;
   logic       w_is_ralu, w_is_imm, w_is_ldi, w_is_ld, w_is_st, w_is_halt;
   logic       w_is_based;
   logic       w_unused_ir;

   assign w_opcode    = bus.IR[31:27];
   assign w_unused_ir = ^bus.IR[26:0];

   assign w_is_ralu  = (w_opcode >= 5'b00011) && (w_opcode <= 5'b00110);
   assign w_is_imm   = (w_opcode >= 5'b01100) && (w_opcode <= 5'b01110);
   assign w_is_ldi   = (w_opcode == 5'b00001);
   assign w_is_ld    = (w_opcode == 5'b00000);
   assign w_is_st    = (w_opcode == 5'b00010);
   assign w_is_halt  = (w_opcode == 5'b11011);
   assign w_is_based = w_is_ldi || w_is_ld || w_is_st;

   // Immediate ALU ops map onto the matching register-form opcode.
   always_comb begin
      case (w_opcode)
         5'b01101: w_imm_alu = 5'b00101;
         5'b01110: w_imm_alu = 5'b00110;
         default:  w_imm_alu = 5'b00011;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_RST;
      end else begin
         case (r_state)
            S_RST:  r_state <= S_T0;
            S_T0:   r_state <= S_T1;
            S_T1:   if (bus.mem_ready) r_state <= S_T2;
            S_T2:   r_state <= S_T3;
            S_T3: begin
               if (w_is_halt)                       r_state <= S_HALT;
               else if (w_is_ralu || w_is_imm || w_is_based) r_state <= S_T4;
               else                                 r_state <= S_T0;
            end
            S_T4:   r_state <= S_T5;
            S_T5:   r_state <= (w_is_ld || w_is_st) ? S_T6 : S_T0;
            S_T6:   if (w_is_st || bus.mem_ready) r_state <= S_T7;
            S_T7:   if (!w_is_st || bus.mem_ready) r_state <= S_T0;
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_RST;
         endcase
      end
   end

   assign bus.step = r_state;
   assign bus.run  = (r_state != S_RST) && (r_state != S_HALT);

   always_comb begin
      bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPC = 1'b0; bus.PCin = 1'b0;
      bus.Read = 1'b0; bus.Write = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0;
      bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Zlowout = 1'b0;
      bus.Cout = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
      bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
      bus.alu_op = 5'b00000;
      case (r_state)
         S_T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            bus.alu_op = 5'b00011;
         end
         S_T1: begin
            bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
         end
         S_T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
         end
         S_T3: begin
            // Base-addressed forms read Rb through BAout so r0 reads as zero.
            if (w_is_ralu || w_is_imm) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (w_is_based) begin
               bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end
         end
         S_T4: begin
            if (w_is_ralu) begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = w_opcode;
            end else if (w_is_imm) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = w_imm_alu;
            end else if (w_is_based) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = 5'b00011;
            end
         end
         S_T5: begin
            if (w_is_ld || w_is_st) begin
               bus.Zlowout = 1'b1; bus.MARin = 1'b1;
            end else if (w_is_ralu || w_is_imm || w_is_ldi) begin
               bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
         end
         S_T6: begin
            if (w_is_ld) begin
               bus.Read = 1'b1; bus.MDRin = 1'b1;
            end else if (w_is_st) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
            end
         end
         S_T7: begin
            if (w_is_ld) begin
               bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (w_is_st) begin
               bus.Write = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle queues its expected
// step/run/alu_op/strobe word, which is popped and compared on the falling edge.
module tb_control_sequencer;
   logic clock;
   logic clear;
   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobe word order: PCout MARin IncPC PCin Read Write MDRin MDRout IRin
   //                    Yin Zin Zlowout Cout Gra Grb Grc Rin Rout BAout
   localparam logic [18:0] NONE    = 19'd0;
   localparam logic [18:0] PCOUT   = 19'd1 << 18;
   localparam logic [18:0] MARIN   = 19'd1 << 17;
   localparam logic [18:0] INCPC   = 19'd1 << 16;
   localparam logic [18:0] PCIN    = 19'd1 << 15;
   localparam logic [18:0] READ    = 19'd1 << 14;
   localparam logic [18:0] WRITE   = 19'd1 << 13;
   localparam logic [18:0] MDRIN   = 19'd1 << 12;
   localparam logic [18:0] MDROUT  = 19'd1 << 11;
   localparam logic [18:0] IRIN    = 19'd1 << 10;
   localparam logic [18:0] YIN     = 19'd1 << 9;
   localparam logic [18:0] ZIN     = 19'd1 << 8;
   localparam logic [18:0] ZLOWOUT = 19'd1 << 7;
   localparam logic [18:0] COUT    = 19'd1 << 6;
   localparam logic [18:0] GRA     = 19'd1 << 5;
   localparam logic [18:0] GRB     = 19'd1 << 4;
   localparam logic [18:0] GRC     = 19'd1 << 3;
   localparam logic [18:0] RIN     = 19'd1 << 2;
   localparam logic [18:0] ROUT    = 19'd1 << 1;
   localparam logic [18:0] BAOUT   = 19'd1;

   localparam logic [31:0] IR_ADD  = 32'h19BD0000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;

   int n_compared = 0;
   int n_mismatched = 0;

   string       tag_q[$];
   logic [28:0] exp_q[$];

   task automatic check_val(input string tag, input logic [28:0] obs, input logic [28:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got step=%0d run=%0b alu=%05b strobes=%019b, want step=%0d run=%0b alu=%05b strobes=%019b",
                  tag, obs[28:25], obs[24], obs[23:19], obs[18:0],
                  exp[28:25], exp[24], exp[23:19], exp[18:0]);
      end else begin
         $display("ok   %s: step=%0d alu=%05b strobes=%019b", tag, obs[28:25], obs[23:19], obs[18:0]);
      end
   endtask

   function automatic logic [28:0] observed();
      return {bus.step, bus.run, bus.alu_op,
              bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.Read, bus.Write,
              bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
              bus.Cout, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout};
   endfunction

   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         check_val(tag_q.pop_front(), observed(), exp_q.pop_front());
      end
   end

   // One clock cycle: drive inputs for the cycle and queue what the current step must show.
   task automatic cyc(input string tag, input logic clr, input logic [31:0] ir, input logic mr,
                      input logic [3:0] st, input logic [18:0] strobes, input logic [4:0] alu);
      logic run_exp;
      @(posedge clock);
      #1;
      clear = clr;
      bus.IR = ir;
      bus.mem_ready = mr;
      run_exp = (st != 4'd0) && (st != 4'd9);
      tag_q.push_back(tag);
      exp_q.push_back({st, run_exp, alu, strobes});
   endtask

   task automatic fetch(input string name, input logic [31:0] ir, input int t1_wait);
      cyc({name, ".T0"}, 1'b0, ir, 1'b1, 4'd1, PCOUT | MARIN | INCPC | ZIN, 5'b00011);
      for (int i = 0; i < t1_wait; i++)
         cyc({name, ".T1w"}, 1'b0, ir, 1'b0, 4'd2, ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
      cyc({name, ".T1"}, 1'b0, ir, 1'b1, 4'd2, ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
      cyc({name, ".T2"}, 1'b0, ir, 1'b1, 4'd3, MDROUT | IRIN, 5'd0);
   endtask

   task automatic exec_alu(input string name, input logic [31:0] ir, input logic is_imm,
                           input logic base, input logic [4:0] alu);
      fetch(name, ir, 0);
      cyc({name, ".T3"}, 1'b0, ir, 1'b1, 4'd4, GRB | YIN | (base ? BAOUT : ROUT), 5'd0);
      cyc({name, ".T4"}, 1'b0, ir, 1'b1, 4'd5, ZIN | (is_imm ? COUT : (GRC | ROUT)), alu);
      cyc({name, ".T5"}, 1'b0, ir, 1'b1, 4'd6, ZLOWOUT | GRA | RIN, 5'd0);
   endtask

   initial begin
      logic [31:0] ir_ld, ir_st, ir_addi, ir_ori, ir_sub, ir_andi, ir_ldi, ir_nop, ir_bad;
      ir_ld   = {5'b00000, 4'd2, 4'd0, 19'h00055};
      ir_st   = {5'b00010, 4'd4, 4'd1, 19'h00090};
      ir_addi = {5'b01100, 4'd5, 4'd6, 19'h7FFFD};
      ir_ori  = {5'b01110, 4'd1, 4'd2, 19'h00005};
      ir_sub  = {5'b00100, 4'd1, 4'd2, 4'd3, 15'd0};
      ir_andi = {5'b01101, 4'd7, 4'd8, 19'h000FF};
      ir_ldi  = {5'b00001, 4'd9, 4'd0, 19'h00123};
      ir_nop  = {5'b11010, 27'd0};
      ir_bad  = {5'b11111, 27'd0};

      clear = 1'b1;
      bus.IR = 32'd0;
      bus.mem_ready = 1'b1;
      @(posedge clock);

      // Power-up, then clear while holding in T1.
      cyc("pwr.RST", 1'b0, 32'd0, 1'b1, 4'd0, NONE, 5'd0);
      cyc("pwr.T0",  1'b0, 32'd0, 1'b0, 4'd1, PCOUT | MARIN | INCPC | ZIN, 5'b00011);
      cyc("hold.T1", 1'b0, 32'd0, 1'b0, 4'd2, ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
      cyc("hold.T1c", 1'b1, 32'd0, 1'b0, 4'd2, ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
      cyc("clr.RST1", 1'b1, 32'd0, 1'b1, 4'd0, NONE, 5'd0);
      cyc("clr.RST2", 1'b0, 32'd0, 1'b1, 4'd0, NONE, 5'd0);

      exec_alu("add", IR_ADD, 1'b0, 1'b0, 5'b00011);

      // ld with an early mem_ready pulse in T5 and three wait cycles in T6.
      fetch("ld", ir_ld, 0);
      cyc("ld.T3", 1'b0, ir_ld, 1'b1, 4'd4, GRB | BAOUT | YIN, 5'd0);
      cyc("ld.T4", 1'b0, ir_ld, 1'b1, 4'd5, COUT | ZIN, 5'b00011);
      cyc("ld.T5", 1'b0, ir_ld, 1'b1, 4'd6, ZLOWOUT | MARIN, 5'd0);
      for (int i = 0; i < 3; i++)
         cyc("ld.T6w", 1'b0, ir_ld, 1'b0, 4'd7, READ | MDRIN, 5'd0);
      cyc("ld.T6", 1'b0, ir_ld, 1'b1, 4'd7, READ | MDRIN, 5'd0);
      cyc("ld.T7", 1'b0, ir_ld, 1'b0, 4'd8, MDROUT | GRA | RIN, 5'd0);

      // st with a slow fetch; mem_ready low in T6 must be ignored.
      fetch("st", ir_st, 2);
      cyc("st.T3", 1'b0, ir_st, 1'b1, 4'd4, GRB | BAOUT | YIN, 5'd0);
      cyc("st.T4", 1'b0, ir_st, 1'b1, 4'd5, COUT | ZIN, 5'b00011);
      cyc("st.T5", 1'b0, ir_st, 1'b1, 4'd6, ZLOWOUT | MARIN, 5'd0);
      cyc("st.T6", 1'b0, ir_st, 1'b0, 4'd7, GRA | ROUT | MDRIN, 5'd0);
      cyc("st.T7w", 1'b0, ir_st, 1'b0, 4'd8, WRITE, 5'd0);
      cyc("st.T7", 1'b0, ir_st, 1'b1, 4'd8, WRITE, 5'd0);

      exec_alu("addi", ir_addi, 1'b1, 1'b0, 5'b00011);
      exec_alu("ori",  ir_ori,  1'b1, 1'b0, 5'b00110);
      exec_alu("andi", ir_andi, 1'b1, 1'b0, 5'b00101);
      exec_alu("sub",  ir_sub,  1'b0, 1'b0, 5'b00100);
      exec_alu("ldi",  ir_ldi,  1'b1, 1'b1, 5'b00011);

      fetch("nop", ir_nop, 0);
      cyc("nop.T3", 1'b0, ir_nop, 1'b1, 4'd4, NONE, 5'd0);
      fetch("bad", ir_bad, 0);
      cyc("bad.T3", 1'b0, ir_bad, 1'b1, 4'd4, NONE, 5'd0);

      fetch("halt", IR_HALT, 0);
      cyc("halt.T3", 1'b0, IR_HALT, 1'b0, 4'd4, NONE, 5'd0);
      for (int i = 0; i < 4; i++)
         cyc("halt.H", 1'b0, IR_HALT, logic'(i % 2), 4'd9, NONE, 5'd0);
      cyc("halt.Hc", 1'b1, IR_HALT, 1'b1, 4'd9, NONE, 5'd0);
      cyc("halt.RST", 1'b0, IR_HALT, 1'b1, 4'd0, NONE, 5'd0);

      // Clear in the middle of an ld memory wait.
      fetch("ld2", ir_ld, 0);
      cyc("ld2.T3", 1'b0, ir_ld, 1'b1, 4'd4, GRB | BAOUT | YIN, 5'd0);
      cyc("ld2.T4", 1'b0, ir_ld, 1'b1, 4'd5, COUT | ZIN, 5'b00011);
      cyc("ld2.T5", 1'b0, ir_ld, 1'b1, 4'd6, ZLOWOUT | MARIN, 5'd0);
      cyc("ld2.T6c", 1'b1, ir_ld, 1'b0, 4'd7, READ | MDRIN, 5'd0);
      cyc("ld2.RST", 1'b0, ir_ld, 1'b0, 4'd0, NONE, 5'd0);
      cyc("ld2.T0", 1'b0, ir_ld, 1'b1, 4'd1, PCOUT | MARIN | INCPC | ZIN, 5'b00011);

      @(negedge clock);
      #1;
      check_val("drain", 29'(exp_q.size()), 29'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Mini SRC datapath: walks a fetch–decode–execute step sequence and drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the select-and-encode logic, plus the bus, memory and ALU strobes. It sits between the IR register and the datapath. It supports a subset of instructions: ld, ldi, st, R-format add/sub/and/or, addi/andi/ori, nop and halt. Memory accesses wait on a ready handshake.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- IR  in  32  current instruction register; opcode=IR[31:27], Ra=[26:23], Rb=[22:19], Rc=[18:15], C=[18:0]; valid from T3
- mem_ready  in  1  memory done; sampled in wait steps
- PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select strobes to select-and-encode
- alu_op  out  5  ALU operation code, in opcode encoding
- run  out  1  high while executing; low in RST and HALT
- step  out  4  current state, for debug

## Operation
- Moore machine: a registered state; all outputs decode combinationally from the state and the IR opcode. Any strobe not listed for a step is 0. alu_op=00000 outside T0/T4.
- States: RST=0, T0..T7 = 1..8, HALT=9.
- RST → T0 unconditionally. All outputs are 0 in RST.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, alu_op=00011.
  - T1: Zlowout, PCin, Read, MDRin. Hold in T1 while mem_ready=0; all strobes stay asserted while holding.
  - T2: MDRout, IRin.
- Execute, R-ALU (00011 add, 00100 sub, 00101 and, 00110 or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin → T0.
- Execute, immediate (01100 addi, 01101 andi, 01110 ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op = 00011/00101/00110 respectively.
  - T5: Zlowout, Gra, Rin → T0.
- Execute, ldi (00001):
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=00011.
  - T5: Zlowout, Gra, Rin → T0.
- Execute, ld (00000):
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold while mem_ready=0.
  - T7: MDRout, Gra, Rin → T0.
- Execute, st (00010):
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin (Read=0, so MDR loads from the bus).
  - T7: Write; hold while mem_ready=0; then → T0.
- nop (11010) and every unsupported opcode: T3 asserts nothing → T0.
- halt (11011): T3 → HALT. HALT is absorbing until clear; all strobes 0, run=0.
- Exactly one of Gra/Grb/Grc is high in any step that asserts Rin, Rout or BAout. BAout is never high together with Rout.

## Timing
- clear is sampled on the clock edge; it overrides everything, including holds, mid-instruction.
- The cycle after clear is sampled: step=0, all outputs 0, run=0. The following cycle: T0, run=1.
- Instruction latency with mem_ready tied high:
  - R-ALU, immediate, ldi: 6 cycles.
  - ld, st: 8 cycles.
  - nop: 4 cycles.
- Each cycle mem_ready is low in T1, T6 (ld) or T7 (st) adds one cycle. mem_ready is ignored in all other states.
- A mem_ready pulse that arrives before the wait state is not remembered.
- IR must be stable from T3 until the instruction's last step. The opcode is re-decoded every cycle; no latch is kept.

## Test plan
- Reset: assert clear for 2 cycles in arbitrary state, then release → step=0 with all outputs 0 for one cycle, then T0 with PCout=MARin=IncPC=Zin=1 and alu_op=00011.
- add r3,r7,r10 (IR=0x19BD0000), mem_ready=1:
  - T3: Grb=Rout=Yin=1.
  - T4: Grc=Rout=Zin=1, alu_op=00011.
  - T5: Gra=Rin=Zlowout=1.
  - Next T0 exactly 6 cycles after the first T0.
- ld r2,0x55(r0) (opcode 00000, Ra=2, Rb=0, C=0x55): hold mem_ready=0 for 3 cycles in T6 → T6 persists 4 cycles with Read=MDRin=1; then T7 has MDRout=Gra=Rin=1; 11 cycles total.
- st 0x90(r1),r4 (opcode 00010, Ra=4, Rb=1, C=0x90):
  - T3: BAout=Grb=Yin=1.
  - T6: Gra=Rout=MDRin=1, Read=0.
  - T7: Write=1 held until mem_ready=1.
- addi r5,r6,-3 → T4 has Cout=Zin=1, alu_op=00011. ori → alu_op=00110. Opcode 11111 → T3 with no strobes, then T0.
- halt (IR=0xD8000000) → step=9, run=0; mem_ready toggling causes no change. Then clear mid-T6 of a ld → RST, then T0.
